cga_vram_arbiter: RTL and testbench
===================================

// Module: cga_vram_arbiter
// PURPOSE
//  Shares the single 8-bit VRAM port between CGA video fetch (sequencer) and CPU ISA memory cycles.
//  Video fetch always owns RAM during vid_read; CPU accesses are queued and issued only in sequencer ISA windows.
//  Generates cpu_rdy (ISA IOCHRDY wait states) and the muxed ram_a/ram_we_l/ram_wd; sits between cga_sequencer, the ISA glue and VRAM.
// PARAMETERS
//  RAM_LAT       1   cycles from ram_a valid to ram_d valid (1..3)
//  WAIT_TIMEOUT  64  PEND cycles before a forced CPU access (0 = never force)
//  ADDR_W        19  VRAM address width
// PORTS
//  clk            in   1       system clock; single clock domain
//  reset          in   1       synchronous, active-high
//  cpu_req        in   1       level; CPU mem cycle to VRAM active (already synchronised)
//  cpu_we         in   1       1=write, 0=read; valid with cpu_req
//  cpu_a          in   15      CPU VRAM offset (32K window)
//  cpu_d          in   8       CPU write data
//  cpu_q          out  8       CPU read data, held until next read completes
//  cpu_rdy        out  1       0 = insert ISA wait state
//  vid_read       in   1       sequencer video fetch cycle (has priority)
//  vid_a          in   ADDR_W  video fetch address
//  isa_op_enable  in   1       sequencer window in which a CPU access may start
//  ram_a          out  ADDR_W  VRAM address
//  ram_we_l       out  1       VRAM write strobe, active low
//  ram_wd         out  8       VRAM write data
//  ram_d          in   8       VRAM read data
//  vid_q          out  8       data to pixel pipeline
//  snow           out  1       video data corrupted by CPU access this cycle
// BEHAVIOUR
//  Reset: state IDLE, cpu_rdy=1, ram_we_l=1, cpu_q=0, snow=0, counters 0; ram_a=vid_a.
//  FSM IDLE -> PEND -> ACC -> DONE -> IDLE:
//   IDLE: rising edge of cpu_req captures {cpu_we,cpu_a,cpu_d}; cpu_rdy<=0 same edge; -> PEND.
//   PEND: start when isa_op_enable=1 & vid_read=0 -> ACC; else wait_cnt++; wait_cnt==WAIT_TIMEOUT-1 -> ACC (forced).
//   ACC: lasts RAM_LAT+1 cycles; ram_a={4'h0,cap_a}; writes: ram_we_l=0 all ACC cycles, ram_wd=cap_d.
//        Reads: cpu_q<=ram_d on last ACC cycle. -> DONE.
//   DONE: cpu_rdy=1; hold until cpu_req=0 -> IDLE. New request needs cpu_req low >=1 cycle.
//  vid_read=1 during non-forced ACC: video wins; CPU access aborted (no partial write), ram_we_l=1, back to PEND.
//  Outside ACC: ram_a=vid_a, ram_we_l=1, vid_q=ram_d.
//  cpu_req dropping in PEND/ACC (bus abort): finish access, skip DONE hold, -> IDLE.
//  Latency best case: request edge to cpu_rdy=1 = 1 + (RAM_LAT+1) + 1 cycles.
//  wait_cnt width $clog2(WAIT_TIMEOUT+1); saturates, cleared on leaving PEND.
//  Reset mid-ACC: write strobe deasserted in the reset cycle; captured request discarded.
// CONFIGURATION
//  CGA_SNOW_EN defined: CPU accesses start on any isa_op_enable, even with vid_read=1; no abort.
//   Video cycles overlapping ACC get vid_q=CPU data (write: cap_d; read: ram_d) and snow=1.
//  Undefined: behaviour as above; snow tied 0; vid_q never corrupted.
// STRUCTURE
//  Package cga_vram_arb_pkg: state enum {IDLE,PEND,ACC,DONE}, ADDR_W default, RAM_LAT bounds.
//  Sub-module cga_vram_arb_timer: ACC latency counter plus PEND watchdog; FSM and muxes stay top-level.
// TESTING
//  1 Write 0x5A to cpu_a=0x0123, isa_op_enable=1, vid_read=0 -> ram_we_l low 2 cycles at ram_a=0x00123, cpu_rdy low 3 cycles.
//  2 Read, ram_d=0xC3 at 0x07FF, window opens 10 cycles later -> cpu_rdy low 13 cycles, cpu_q=0xC3.
//  3 isa_op_enable held 0, WAIT_TIMEOUT=64 -> forced ACC after 64 PEND cycles, cpu_rdy rises.
//  4 vid_read asserts mid-ACC on a write -> no write issued, ram_a=vid_a that cycle, retried in next window.
//  5 CGA_SNOW_EN, write 0xFF overlapping vid_read -> vid_q=0xFF, snow=1 for overlap only.
//  6 reset pulse during ACC write -> ram_we_l=1 same cycle, cpu_rdy=1, state IDLE, RAM unchanged.

Source files
------------

// File: rtl/cga_vram_arb_pkg.sv
// Shared types and constants for the CGA VRAM arbiter: FSM state encoding,
// default address width and the supported RAM latency range.
package cga_vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    localparam int ADDR_W_DEF  = 19;
    localparam int CPU_A_W     = 15;
    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 3;

    // Keeps an out-of-range RAM latency inside what the ACC counter can time.
    function automatic int clamp_lat(input int lat);
        if (lat < RAM_LAT_MIN) begin
            return RAM_LAT_MIN;
        end else if (lat > RAM_LAT_MAX) begin
            return RAM_LAT_MAX;
        end else begin
            return lat;
        end
    endfunction

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// CPU, video-fetch and VRAM signal bundle of the arbiter; the arbiter takes
// the slave view, the surrounding glue (or a bench) the master view.
interface cga_vram_arbiter_if #(
    parameter int ADDR_W = cga_vram_arb_pkg::ADDR_W_DEF
);
    logic                                 cpu_req;
    logic                                 cpu_we;
    logic [cga_vram_arb_pkg::CPU_A_W-1:0] cpu_a;
    logic [7:0]                           cpu_d;
    logic [7:0]                           cpu_q;
    logic                                 cpu_rdy;
    logic                                 vid_read;
    logic [ADDR_W-1:0]                    vid_a;
    logic                                 isa_op_enable;
    logic [ADDR_W-1:0]                    ram_a;
    logic                                 ram_we_l;
    logic [7:0]                           ram_wd;
    logic [7:0]                           ram_d;
    logic [7:0]                           vid_q;
    logic                                 snow;

    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_d, vid_read, vid_a, isa_op_enable, ram_d,
        output cpu_q, cpu_rdy, ram_a, ram_we_l, ram_wd, vid_q, snow
    );

    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_d, vid_read, vid_a, isa_op_enable, ram_d,
        input  cpu_q, cpu_rdy, ram_a, ram_we_l, ram_wd, vid_q, snow
    );
endinterface

// File: rtl/cga_vram_arb_timer.sv
// ACC-phase latency counter and PEND watchdog for the CGA VRAM arbiter.
// Both counters clear whenever their phase is not active.
module cga_vram_arb_timer
    import cga_vram_arb_pkg::*;
#(
    parameter int RAM_LAT      = 1,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic acc_i,
    input  logic pend_wait_i,
    output logic acc_last_o,
    output logic wd_expire_o
);
    localparam int WAIT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [1:0] ACC_LAST = 2'(clamp_lat(RAM_LAT));
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
    localparam bit WD_EN = (WAIT_TIMEOUT > 0);

    logic [1:0]        acc_cnt_q, acc_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign acc_last_o  = (acc_cnt_q == ACC_LAST);
    assign wd_expire_o = WD_EN && (wait_cnt_q == WAIT_LAST);

    // Next-count logic; the wait counter saturates so WAIT_TIMEOUT=0 never wraps.
    always_comb begin
        acc_cnt_d  = 2'd0;
        wait_cnt_d = '0;
        if (acc_i && !acc_last_o) begin
            acc_cnt_d = acc_cnt_q + 2'd1;
        end else begin
            acc_cnt_d = 2'd0;
        end
        if (pend_wait_i && !wd_expire_o) begin
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end else begin
            wait_cnt_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_q  <= 2'd0;
            wait_cnt_q <= '0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the 8-bit VRAM port between CGA video fetch and queued CPU ISA cycles.
// Optional feature macro CGA_SNOW_EN: CPU cycles may collide with video fetch (snow).
module cga_vram_arbiter
    import cga_vram_arb_pkg::*;
#(
    parameter int RAM_LAT      = 1,
    parameter int WAIT_TIMEOUT = 64,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input logic                clk,
    input logic                reset,
    cga_vram_arbiter_if.slave  bus
);
    arb_state_e           state_q, state_d;
    logic                 cap_we_q, cap_we_d;
    logic [CPU_A_W-1:0]   cap_a_q, cap_a_d;
    logic [7:0]           cap_d_q, cap_d_d;
    logic [7:0]           cpu_q_q, cpu_q_d;
    logic                 cpu_rdy_q, cpu_rdy_d;
    logic                 forced_q, forced_d;
    logic                 bus_abort_q, bus_abort_d;
    logic                 req_prev_q;

    logic acc_s, start_s, abort_vid_s, cpu_drive_s, pend_wait_s;
    logic acc_last_s, wd_expire_s, req_rise_s;

    assign req_rise_s  = bus.cpu_req & ~req_prev_q;
    // Reset gates the CPU drive so a write strobe drops in the reset cycle itself.
    assign acc_s       = (state_q == ACC) & ~reset;
`ifdef CGA_SNOW_EN
    assign start_s     = bus.isa_op_enable;
    assign abort_vid_s = 1'b0;
`else
    assign start_s     = bus.isa_op_enable & ~bus.vid_read;
    assign abort_vid_s = acc_s & bus.vid_read & ~forced_q;
`endif
    assign cpu_drive_s = acc_s & ~abort_vid_s;
    assign pend_wait_s = (state_q == PEND) & ~start_s;

    cga_vram_arb_timer #(
        .RAM_LAT      (RAM_LAT),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .acc_i       (state_q == ACC),
        .pend_wait_i (pend_wait_s),
        .acc_last_o  (acc_last_s),
        .wd_expire_o (wd_expire_s)
    );

    // Next-state and capture logic of the CPU access FSM.
    always_comb begin
        state_d     = state_q;
        cap_we_d    = cap_we_q;
        cap_a_d     = cap_a_q;
        cap_d_d     = cap_d_q;
        cpu_q_d     = cpu_q_q;
        forced_d    = forced_q;
        bus_abort_d = bus_abort_q;
        case (state_q)
            IDLE: begin
                if (req_rise_s) begin
                    cap_we_d    = bus.cpu_we;
                    cap_a_d     = bus.cpu_a;
                    cap_d_d     = bus.cpu_d;
                    forced_d    = 1'b0;
                    bus_abort_d = 1'b0;
                    state_d     = PEND;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                bus_abort_d = bus_abort_q | ~bus.cpu_req;
                if (start_s) begin
                    forced_d = 1'b0;
                    state_d  = ACC;
                end else if (wd_expire_s) begin
                    forced_d = 1'b1;
                    state_d  = ACC;
                end else begin
                    state_d = PEND;
                end
            end
            ACC: begin
                bus_abort_d = bus_abort_q | ~bus.cpu_req;
                if (abort_vid_s) begin
                    state_d = PEND;
                end else if (acc_last_s) begin
                    if (!cap_we_q) begin
                        cpu_q_d = bus.ram_d;
                    end else begin
                        cpu_q_d = cpu_q_q;
                    end
                    state_d = (bus_abort_q || !bus.cpu_req) ? IDLE : DONE;
                end else begin
                    state_d = ACC;
                end
            end
            DONE: begin
                if (!bus.cpu_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cpu_rdy_d = (state_d == IDLE) || (state_d == DONE);
    end

    // FSM and capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cap_we_q    <= 1'b0;
            cap_a_q     <= '0;
            cap_d_q     <= 8'h00;
            cpu_q_q     <= 8'h00;
            cpu_rdy_q   <= 1'b1;
            forced_q    <= 1'b0;
            bus_abort_q <= 1'b0;
            req_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_we_q    <= cap_we_d;
            cap_a_q     <= cap_a_d;
            cap_d_q     <= cap_d_d;
            cpu_q_q     <= cpu_q_d;
            cpu_rdy_q   <= cpu_rdy_d;
            forced_q    <= forced_d;
            bus_abort_q <= bus_abort_d;
            req_prev_q  <= bus.cpu_req;
        end
    end

    assign bus.ram_a    = cpu_drive_s ? ADDR_W'(cap_a_q) : bus.vid_a;
    assign bus.ram_we_l = ~(cpu_drive_s & cap_we_q);
    assign bus.ram_wd   = cap_d_q;
    assign bus.cpu_q    = cpu_q_q;
    assign bus.cpu_rdy  = cpu_rdy_q;

`ifdef CGA_SNOW_EN
    assign bus.snow  = cpu_drive_s & bus.vid_read;
    assign bus.vid_q = (cpu_drive_s && cap_we_q) ? cap_d_q : bus.ram_d;
`else
    logic [7:0] vid_last_q;

    // Last clean video byte, replayed to the pixel pipe while the CPU owns RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_last_q <= 8'h00;
        end else if (!acc_s) begin
            vid_last_q <= bus.ram_d;
        end
    end

    assign bus.snow  = 1'b0;
    assign bus.vid_q = acc_s ? vid_last_q : bus.ram_d;
`endif

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter: stimulus pushes expected CPU completions
// (wait-state count, cpu_q) into a scoreboard that a cpu_rdy monitor checks.
module tb_cga_vram_arbiter;

    typedef struct {
        int         low;
        logic [7:0] q;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cga_vram_arbiter_if #(.ADDR_W(19)) bus ();

    cga_vram_arbiter #(
        .RAM_LAT      (1),
        .WAIT_TIMEOUT (64),
        .ADDR_W       (19)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // VRAM model: one-cycle read latency, initial contents addr[7:0] ^ 0x3C.
    logic [7:0] mem [0:4095];
    logic [7:0] rd_q;
    logic       mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h3C;
            mem_ready <= 1'b1;
        end else if (bus.ram_we_l === 1'b0) begin
            mem[bus.ram_a[11:0]] <= bus.ram_wd;
        end
        rd_q <= mem[bus.ram_a[11:0]];
    end
    assign bus.ram_d = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int low, input logic [7:0] q);
        exp_t e;
        e.low = low;
        e.q   = q;
        sb.push_back(e);
    endtask

    task automatic wait_rdy(input int budget, input string name);
        int n = 0;
        while (bus.cpu_rdy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, bus.cpu_rdy}, 32'd1);
    endtask

    task automatic start_req(input logic we, input logic [14:0] a, input logic [7:0] d,
                             input logic isa, input logic vid);
        bus.cpu_req       = 1'b1;
        bus.cpu_we        = we;
        bus.cpu_a         = a;
        bus.cpu_d         = d;
        bus.isa_op_enable = isa;
        bus.vid_read      = vid;
    endtask

    // Monitor: on each cpu_rdy rise, compare wait states and cpu_q against the queue.
    initial begin : monitor
        int   low_cnt;
        logic prev;
        exp_t e;
        low_cnt = 0;
        prev    = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.cpu_rdy === 1'b0) begin
                low_cnt++;
            end else if (bus.cpu_rdy === 1'b1 && prev === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rdy_low_cycles", low_cnt, e.low);
                    chk("cpu_q", {24'd0, bus.cpu_q}, {24'd0, e.q});
                end
                low_cnt = 0;
            end
            prev = bus.cpu_rdy;
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1);
    end

    initial begin : stim
        reset             = 1'b1;
        bus.cpu_req       = 1'b0;
        bus.cpu_we        = 1'b0;
        bus.cpu_a         = 15'h0000;
        bus.cpu_d         = 8'h00;
        bus.vid_read      = 1'b0;
        bus.vid_a         = 19'h00040;
        bus.isa_op_enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cpu_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
        chk("rst_ram_we_l", {31'd0, bus.ram_we_l}, 32'd1);
        chk("rst_cpu_q", {24'd0, bus.cpu_q}, 32'h00);
        chk("rst_snow", {31'd0, bus.snow}, 32'd0);
        chk("rst_ram_a", {13'd0, bus.ram_a}, 32'h00040);
        chk("rst_vid_q", {24'd0, bus.vid_q}, 32'h7C);

        // 1: write 0x5A to 0x0123 with the window open
        start_req(1'b1, 15'h0123, 8'h5A, 1'b1, 1'b0);
        push_exp(3, 8'h00);
        @(negedge clk);
        chk("t1_pend_we_l", {31'd0, bus.ram_we_l}, 32'd1);
        @(negedge clk);
        chk("t1_acc1_we_l", {31'd0, bus.ram_we_l}, 32'd0);
        chk("t1_ram_a", {13'd0, bus.ram_a}, 32'h00123);
        chk("t1_ram_wd", {24'd0, bus.ram_wd}, 32'h5A);
        @(negedge clk);
        chk("t1_acc2_we_l", {31'd0, bus.ram_we_l}, 32'd0);
        wait_rdy(8, "t1_rdy_timeout");
        chk("t1_done_we_l", {31'd0, bus.ram_we_l}, 32'd1);
        chk("t1_mem", {24'd0, mem[12'h123]}, 32'h5A);
        bus.cpu_req = 1'b0;
        @(negedge clk);

        // 2: read 0x07FF, window opens 10 cycles late
        start_req(1'b0, 15'h07FF, 8'h00, 1'b0, 1'b0);
        push_exp(13, 8'hC3);
        repeat (11) @(negedge clk);
        chk("t2_pend_ram_a", {13'd0, bus.ram_a}, 32'h00040);
        bus.isa_op_enable = 1'b1;
        wait_rdy(8, "t2_rdy_timeout");
        bus.cpu_req = 1'b0;
        @(negedge clk);

        // 3: window never opens, watchdog forces the write
        start_req(1'b1, 15'h0200, 8'h11, 1'b0, 1'b0);
        push_exp(66, 8'hC3);
        repeat (64) @(negedge clk);
        chk("t3_pend64_we_l", {31'd0, bus.ram_we_l}, 32'd1);
        @(negedge clk);
        chk("t3_forced_we_l", {31'd0, bus.ram_we_l}, 32'd0);
        chk("t3_forced_ram_a", {13'd0, bus.ram_a}, 32'h00200);
        wait_rdy(8, "t3_rdy_timeout");
        chk("t3_mem", {24'd0, mem[12'h200]}, 32'h11);
        bus.cpu_req = 1'b0;
        @(negedge clk);

`ifndef CGA_SNOW_EN
        // 4: video fetch aborts a write in ACC, retried in the next window
        start_req(1'b1, 15'h0300, 8'h77, 1'b1, 1'b0);
        push_exp(6, 8'hC3);
        repeat (2) @(negedge clk);
        bus.vid_read = 1'b1;
        #1;
        chk("t4_abort_we_l", {31'd0, bus.ram_we_l}, 32'd1);
        chk("t4_abort_ram_a", {13'd0, bus.ram_a}, 32'h00040);
        @(negedge clk);
        chk("t4_mem_untouched", {24'd0, mem[12'h300]}, 32'h3C);
        chk("t4_pend_we_l", {31'd0, bus.ram_we_l}, 32'd1);
        @(negedge clk);
        bus.vid_read = 1'b0;
        wait_rdy(10, "t4_rdy_timeout");
        chk("t4_mem", {24'd0, mem[12'h300]}, 32'h77);
        bus.cpu_req = 1'b0;
        @(negedge clk);
`endif

`ifdef CGA_SNOW_EN
        // 5: write overlapping a video fetch shows up as snow
        start_req(1'b1, 15'h0400, 8'hFF, 1'b1, 1'b0);
        push_exp(3, 8'hC3);
        repeat (2) @(negedge clk);
        bus.vid_read = 1'b1;
        #1;
        chk("t5_snow_vid_q", {24'd0, bus.vid_q}, 32'hFF);
        chk("t5_snow", {31'd0, bus.snow}, 32'd1);
        chk("t5_we_l", {31'd0, bus.ram_we_l}, 32'd0);
        @(negedge clk);
        bus.vid_read = 1'b0;
        #1;
        chk("t5_snow_off", {31'd0, bus.snow}, 32'd0);
        wait_rdy(8, "t5_rdy_timeout");
        chk("t5_done_snow", {31'd0, bus.snow}, 32'd0);
        chk("t5_mem", {24'd0, mem[12'h400]}, 32'hFF);
        bus.cpu_req = 1'b0;
        @(negedge clk);
`else
        // 5: without snow a video fetch holds the CPU back and vid_q stays clean
        start_req(1'b1, 15'h0400, 8'hFF, 1'b1, 1'b1);
        push_exp(4, 8'hC3);
        @(negedge clk);
        chk("t5_snow", {31'd0, bus.snow}, 32'd0);
        chk("t5_blocked_we_l", {31'd0, bus.ram_we_l}, 32'd1);
        @(negedge clk);
        chk("t5_still_blocked", {31'd0, bus.ram_we_l}, 32'd1);
        bus.vid_read = 1'b0;
        @(negedge clk);
        chk("t5_acc_we_l", {31'd0, bus.ram_we_l}, 32'd0);
        chk("t5_acc1_vid_q", {24'd0, bus.vid_q}, 32'h7C);
        chk("t5_acc_snow", {31'd0, bus.snow}, 32'd0);
        @(negedge clk);
        chk("t5_acc2_vid_q", {24'd0, bus.vid_q}, 32'h7C);
        wait_rdy(8, "t5_rdy_timeout");
        chk("t5_mem", {24'd0, mem[12'h400]}, 32'hFF);
        bus.cpu_req = 1'b0;
        @(negedge clk);
`endif

        // 6: reset in the first ACC cycle of a write
        start_req(1'b1, 15'h0500, 8'h99, 1'b1, 1'b0);
        push_exp(2, 8'h00);
        repeat (2) @(negedge clk);
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        #1;
        chk("t6_rst_we_l", {31'd0, bus.ram_we_l}, 32'd1);
        chk("t6_rst_ram_a", {13'd0, bus.ram_a}, 32'h00040);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_cpu_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
        chk("t6_mem_unchanged", {24'd0, mem[12'h500]}, 32'h3C);
        @(negedge clk);
        chk("t6_idle_we_l", {31'd0, bus.ram_we_l}, 32'd1);

        // 7: read whose request drops while pending still completes
        start_req(1'b0, 15'h0010, 8'h00, 1'b0, 1'b0);
        push_exp(5, 8'h2C);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        bus.isa_op_enable = 1'b1;
        wait_rdy(10, "t7_rdy_timeout");
        @(negedge clk);
        chk("t7_after_we_l", {31'd0, bus.ram_we_l}, 32'd1);

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
